// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction classes, opcodes and loader FSM states.
// The opcode constants are the same ones the main control decoder matches on.
package mips_pkg;

  typedef enum logic [3:0] {
    CLS_RTYPE = 4'd0,
    CLS_LW    = 4'd1,
    CLS_SW    = 4'd2,
    CLS_BEQ   = 4'd3,
    CLS_BNE   = 4'd4,
    CLS_BGTZ  = 4'd5,
    CLS_ADDI  = 4'd6,
    CLS_ANDI  = 4'd7,
    CLS_ORI   = 4'd8,
    CLS_SLTI  = 4'd9
  } instrClass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } loaderState_t;

endpackage

// File: rtl/instr_word_packer.sv
// Combinational packer: instruction class plus fields into a 32-bit MIPS word.
// supported is low for any class code the control decoder does not handle.
module instr_word_packer
  import mips_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        supported
);

  always_comb begin
    word      = '0;
    supported = 1'b1;
    case (cls)
      CLS_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      CLS_LW:    word = {OP_LW,   rs, rt, imm};
      CLS_SW:    word = {OP_SW,   rs, rt, imm};
      CLS_BEQ:   word = {OP_BEQ,  rs, rt, imm};
      CLS_BNE:   word = {OP_BNE,  rs, rt, imm};
      // bgtz has no second source register; the rt slot is architecturally zero
      CLS_BGTZ:  word = {OP_BGTZ, rs, 5'b00000, imm};
      CLS_ADDI:  word = {OP_ADDI, rs, rt, imm};
      CLS_ANDI:  word = {OP_ANDI, rs, rt, imm};
      CLS_ORI:   word = {OP_ORI,  rs, rt, imm};
      CLS_SLTI:  word = {OP_SLTI, rs, rt, imm};
      default:   supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction-memory loader: accepts symbolic instructions over valid/ready,
// encodes them and streams one word per cycle into the memory write port.
module instr_encoder_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic              in_last,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic              error
);

  loaderState_t      state;
  loaderState_t      stateNext;
  logic              accept;
  logic [31:0]       packedWord;
  logic              supported;
  logic [ADDR_W-1:0] writeAddr;
  logic [ADDR_W:0]   countNext;
  logic              hitDepth;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       word_p1;

  instr_word_packer packer (
    .cls       (in_class),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .imm       (imm),
    .word      (packedWord),
    .supported (supported)
  );

  assign accept    = in_valid && in_ready;
  assign countNext = count + (ADDR_W+1)'(1);
  assign hitDepth  = (countNext == (ADDR_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (start) begin
      stateNext = LOAD;
    end else if (state == LOAD && accept) begin
      if (!supported)                stateNext = ERR;
      else if (in_last || hitDepth)  stateNext = DONE;
    end
  end

  // start wins over a same-cycle beat, so ready drops while it is high
  always_comb begin
    in_ready = (state == LOAD) && !start;
    done     = (state == DONE);
    error    = (state == ERR);
  end

  // Stage p0 -> p1: accepted beat becomes a registered memory write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      addr_p1   <= ADDR_W'(BASE);
      word_p1   <= '0;
      writeAddr <= ADDR_W'(BASE);
      count     <= '0;
      full      <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (start) begin
        addr_p1   <= ADDR_W'(BASE);
        writeAddr <= ADDR_W'(BASE);
        count     <= '0;
        full      <= 1'b0;
      end else if (accept && supported) begin
        vld_p1    <= 1'b1;
        word_p1   <= packedWord;
        addr_p1   <= writeAddr;
        writeAddr <= writeAddr + ADDR_W'(1);
        count     <= countNext;
        full      <= hitDepth && !in_last;
      end
    end
  end

  assign mem_we    = vld_p1;
  assign mem_addr  = addr_p1;
  assign mem_wdata = word_p1;

endmodule
